// File: rtl/shreg_frame_tx_if.sv
// Load handshake between the universal shift register and the serial frame transmitter.
// The master offers a parallel word; the slave signals when it can take one.
interface shreg_frame_tx_if;
  localparam int unsigned DATA_W = 8;

  logic [DATA_W-1:0] data_in;
  logic              load_valid;
  logic              load_ready;

  modport master (output data_in, output load_valid, input load_ready);
  modport slave  (input data_in, input load_valid, output load_ready);
endinterface

// File: rtl/shreg_frame_tx.sv
// Async-serial frame transmitter: start, 8 data bits LSB first, optional even parity, stop.
// Captures a word on the load handshake and shifts it out on tx_out, which idles high.
module shreg_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  shreg_frame_tx_if.slave   load,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned BAUD_W = 8;
  localparam int unsigned BIT_W  = 3;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  // Next-state logic; every register holds while ena is low, and done only pulses when enabled.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    buf_d   = buf_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (ena) begin
      unique case (state_q)
        S_IDLE: begin
          if (load.load_valid) begin
            state_d = S_START;
            baud_d  = '0;
            buf_d   = load.data_in;
            par_d   = ^load.data_in;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_d = S_DATA;
            baud_d  = '0;
            bit_d   = '0;
            tx_d    = buf_q[0];
          end else begin
            baud_d  = baud_q + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_d = '0;
            buf_d  = buf_q >> 1;
            if (bit_q == BIT_LAST) begin
              if (PARITY_EN) begin
                state_d = S_PARITY;
                tx_d    = par_q;
              end else begin
                state_d = S_STOP;
                tx_d    = 1'b1;
              end
            end else begin
              bit_d = bit_q + BIT_W'(1);
              tx_d  = buf_q[1];
            end
          end else begin
            baud_d = baud_q + BAUD_W'(1);
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state_d = S_STOP;
            baud_d  = '0;
            tx_d    = 1'b1;
          end else begin
            baud_d  = baud_q + BAUD_W'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            state_d = S_IDLE;
            baud_d  = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            baud_d  = baud_q + BAUD_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          baud_d  = '0;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      buf_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      buf_q   <= buf_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign load.load_ready = ena & (state_q == S_IDLE);
  assign tx_out          = tx_q;
  assign busy            = busy_q;
  assign done            = done_q;
endmodule

// File: tb/tb_shreg_frame_tx.sv
// Directed bench for shreg_frame_tx: three instances cover parity on/off and one-cycle bits.
module tb_shreg_frame_tx;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] din;
  logic [2:0] lv;
  wire  [2:0] tx_v, busy_v, done_v, lr_v;
  int         cpb [3];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  shreg_frame_tx_if if0 ();
  shreg_frame_tx_if if1 ();
  shreg_frame_tx_if if2 ();

  assign if0.data_in = din;  assign if0.load_valid = lv[0];  assign lr_v[0] = if0.load_ready;
  assign if1.data_in = din;  assign if1.load_valid = lv[1];  assign lr_v[1] = if1.load_ready;
  assign if2.data_in = din;  assign if2.load_valid = lv[2];  assign lr_v[2] = if2.load_ready;

  shreg_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load(if0),
    .tx_out(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  shreg_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load(if1),
    .tx_out(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  shreg_frame_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load(if2),
    .tx_out(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  typedef struct {
    int          sel;
    logic [7:0]  data;
    logic [10:0] exp;
    int          nbits;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Offer a word at a falling edge and return right after the accepting rising edge.
  task automatic send(input int sel, input logic [7:0] data);
    @(negedge clk);
    din     = data;
    lv[sel] = 1'b1;
    chk($sformatf("ready_before_%0h", data), lr_v[sel], 1'b1);
    @(posedge clk);
  endtask

  // Check every cycle of a frame, then the done cycle; optional hold of load_valid and ena pause.
  task automatic check_frame(input int sel, input string tag, input logic [10:0] exp,
                             input int nbits, input bit hold, input logic [7:0] next_data,
                             input int pause_at, input int pause_len);
    int n;
    logic b;
    n = nbits * cpb[sel];
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c == 0 && !hold) lv[sel] = 1'b0;
      b = exp[nbits - 1 - c / cpb[sel]];
      chk($sformatf("%s_tx_c%0d", tag, c), tx_v[sel], b);
      chk($sformatf("%s_busy_c%0d", tag, c), busy_v[sel], 1'b1);
      chk($sformatf("%s_done_c%0d", tag, c), done_v[sel], 1'b0);
      if (hold && c == 5) din = 8'hFF;
      if (hold && c == n - 1) din = next_data;
      if (c == pause_at) begin
        ena = 1'b0;
        for (int p = 0; p < pause_len; p++) begin
          @(negedge clk);
          chk($sformatf("%s_frz_tx_p%0d", tag, p), tx_v[sel], b);
          chk($sformatf("%s_frz_done_p%0d", tag, p), done_v[sel], 1'b0);
          chk($sformatf("%s_frz_ready_p%0d", tag, p), lr_v[sel], 1'b0);
        end
        ena = 1'b1;
      end
    end
    @(negedge clk);
    chk($sformatf("%s_done", tag), done_v[sel], 1'b1);
    chk($sformatf("%s_idle_busy", tag), busy_v[sel], 1'b0);
    chk($sformatf("%s_idle_tx", tag), tx_v[sel], 1'b1);
    if (hold) chk($sformatf("%s_ready_on_done", tag), lr_v[sel], 1'b1);
  endtask

  initial begin
    cpb[0] = 4; cpb[1] = 4; cpb[2] = 1;
    vecs[0] = '{0, 8'hA5, 11'b0_10100101_0_1, 11};
    vecs[1] = '{1, 8'h07, 11'(10'b0_11100000_1), 10};
    vecs[2] = '{0, 8'h07, 11'b0_11100000_1_1, 11};
    vecs[3] = '{2, 8'hA5, 11'b0_10100101_0_1, 11};
    vecs[4] = '{2, 8'h01, 11'b0_10000000_1_1, 11};
    vecs[5] = '{1, 8'hFF, 11'(10'b0_11111111_1), 10};
    vecs[6] = '{0, 8'h00, 11'b0_00000000_0_1, 11};

    rst_n = 1'b0; ena = 1'b1; din = 8'h00; lv = 3'b000;

    // Reset state, held and then released
    repeat (2) @(negedge clk);
    chk("rst_tx", tx_v[0], 1'b1);
    chk("rst_ready", lr_v[0], 1'b1);
    chk("rst_busy", busy_v[0], 1'b0);
    chk("rst_done", done_v[0], 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rel_tx", tx_v[0], 1'b1);
    chk("rel_ready", lr_v[0], 1'b1);
    chk("rel_busy", busy_v[0], 1'b0);
    chk("rel_done", done_v[0], 1'b0);

    ena = 1'b0;
    #1 chk("ena0_ready", lr_v[0], 1'b0);
    ena = 1'b1;

    // Table-driven frames across parity settings and bit periods
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].sel, vecs[i].data);
      check_frame(vecs[i].sel, $sformatf("v%0d", i), vecs[i].exp, vecs[i].nbits, 1'b0, 8'h00, -1, 0);
    end

    // Back-to-back with load_valid held; 0xFF offered mid-frame must be dropped
    send(0, 8'h3C);
    check_frame(0, "b2b_a", 11'b0_00111100_0_1, 11, 1'b1, 8'hC3, -1, 0);
    @(posedge clk);
    check_frame(0, "b2b_b", 11'b0_11000011_0_1, 11, 1'b0, 8'h00, -1, 0);
    repeat (3) @(negedge clk);
    chk("b2b_no_third", busy_v[0], 1'b0);

    // Ena low for 10 cycles in data bit 3, then ena low across the stop-to-idle edge
    send(0, 8'hA5);
    check_frame(0, "ena_mid", 11'b0_10100101_0_1, 11, 1'b0, 8'h00, 17, 10);
    send(0, 8'h07);
    check_frame(0, "ena_done", 11'b0_11100000_1_1, 11, 1'b0, 8'h00, 43, 3);

    // Async reset at data bit 5 of 0x55 abandons the frame
    send(0, 8'h55);
    for (int c = 0; c <= 25; c++) begin
      @(negedge clk);
      if (c == 0) lv[0] = 1'b0;
    end
    chk("rst_mid_pre_tx", tx_v[0], 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", tx_v[0], 1'b1);
    chk("rst_mid_busy", busy_v[0], 1'b0);
    chk("rst_mid_done", done_v[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_nodone_c%0d", c), done_v[0], 1'b0);
    end
    send(0, 8'h81);
    check_frame(0, "after_rst", 11'b0_10000001_0_1, 11, 1'b0, 8'h00, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
